// File: rtl/pem_pkg.sv
// Shared definitions for the fetch/decode control stage: word widths,
// locally resolved opcodes and the FSM state encoding.
package pem_pkg;

    localparam int LARGURA_DADOS  = 8;
    localparam int LARGURA_END    = 4;
    localparam int LARGURA_OPCODE = LARGURA_DADOS - LARGURA_END;

    localparam logic [LARGURA_OPCODE-1:0] OP_NOP  = 4'h0;
    localparam logic [LARGURA_OPCODE-1:0] OP_JZ   = 4'hD;
    localparam logic [LARGURA_OPCODE-1:0] OP_JMP  = 4'hE;
    localparam logic [LARGURA_OPCODE-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        BUSCA      = 3'd1,
        DECODIFICA = 3'd2,
        EXECUTA    = 3'd3,
        PARADO     = 3'd4
    } estado_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Valid/ready link between the control unit (master) and the ULA (slave).
interface unidade_controle_if;

    logic [pem_pkg::LARGURA_OPCODE-1:0] opcode;
    logic [pem_pkg::LARGURA_END-1:0]    operando;
    logic                               opValido;
    logic                               ulaPronto;

    modport master (output opcode, output operando, output opValido, input ulaPronto);
    modport slave  (input opcode, input operando, input opValido, output ulaPronto);

endinterface

// File: rtl/memoria_programa.sv
// 16x8 program memory: one synchronous write port and one registered read
// port; contents survive reset.
module memoria_programa
    import pem_pkg::*;
(
    input  logic                     clk,
    input  logic                     escrita,
    input  logic [LARGURA_END-1:0]   endereco_escrita,
    input  logic [LARGURA_DADOS-1:0] dado_escrita,
    input  logic                     leitura,
    input  logic [LARGURA_END-1:0]   endereco_leitura,
    output logic [LARGURA_DADOS-1:0] dado_lido
);

    logic [LARGURA_DADOS-1:0] mem [2**LARGURA_END];

    // The read register doubles as the instruction register and only updates during fetch.
    always_ff @(posedge clk) begin
        if (escrita) begin
            mem[endereco_escrita] <= dado_escrita;
        end
        if (leitura) begin
            dado_lido <= mem[endereco_leitura];
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Fetch/decode/execute control unit: resolves NOP/JZ/JMP/HALT locally and
// hands every other instruction to the ULA over a valid/ready handshake.
module unidade_controle
    import pem_pkg::*;
(
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [LARGURA_DADOS-1:0] dadosEntrada,
    input  logic [LARGURA_END-1:0]   enderecoEscrita,
    input  logic                     escrever,
    input  logic                     iniciar,
    input  logic                     acumuladorZero,
    unidade_controle_if.master       ula,
    output logic [LARGURA_END-1:0]   pc,
    output logic                     executando,
    output logic                     parado
);

    localparam logic [2:0] S_OCIOSO     = OCIOSO;
    localparam logic [2:0] S_BUSCA      = BUSCA;
    localparam logic [2:0] S_DECODIFICA = DECODIFICA;
    localparam logic [2:0] S_EXECUTA    = EXECUTA;
    localparam logic [2:0] S_PARADO     = PARADO;

    logic [2:0]                estado;
    logic [LARGURA_DADOS-1:0]  ir;
    logic [LARGURA_OPCODE-1:0] ir_opcode;
    logic [LARGURA_END-1:0]    ir_operando;
    logic                      ocioso;

    assign ocioso      = (estado == S_OCIOSO) || (estado == S_PARADO);
    assign executando  = !ocioso;
    assign ir_opcode   = ir[LARGURA_DADOS-1:LARGURA_END];
    assign ir_operando = ir[LARGURA_END-1:0];

    memoria_programa u_memoria (
        .clk              (Clock),
        .escrita          (escrever && ocioso),
        .endereco_escrita (enderecoEscrita),
        .dado_escrita     (dadosEntrada),
        .leitura          (estado == S_BUSCA),
        .endereco_leitura (pc),
        .dado_lido        (ir)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            estado       <= S_OCIOSO;
            pc           <= '0;
            ula.opcode   <= '0;
            ula.operando <= '0;
            ula.opValido <= 1'b0;
            parado       <= 1'b0;
        end else begin
            case (estado)
                S_OCIOSO: begin
                    if (iniciar) begin
                        pc     <= '0;
                        estado <= S_BUSCA;
                    end
                end
                S_BUSCA: begin
                    estado <= S_DECODIFICA;
                end
                S_DECODIFICA: begin
                    case (ir_opcode)
                        OP_NOP: begin
                            pc     <= pc + 1'b1;
                            estado <= S_BUSCA;
                        end
                        OP_JMP: begin
                            pc     <= ir_operando;
                            estado <= S_BUSCA;
                        end
                        OP_JZ: begin
                            pc     <= acumuladorZero ? ir_operando : pc + 1'b1;
                            estado <= S_BUSCA;
                        end
                        OP_HALT: begin
                            parado <= 1'b1;
                            estado <= S_PARADO;
                        end
                        default: begin
                            ula.opcode   <= ir_opcode;
                            ula.operando <= ir_operando;
                            ula.opValido <= 1'b1;
                            estado       <= S_EXECUTA;
                        end
                    endcase
                end
                S_EXECUTA: begin
                    // Operands stay frozen until the ULA takes them.
                    if (ula.ulaPronto) begin
                        ula.opValido <= 1'b0;
                        pc           <= pc + 1'b1;
                        estado       <= S_BUSCA;
                    end
                end
                S_PARADO: begin
                    if (iniciar) begin
                        pc     <= '0;
                        parado <= 1'b0;
                        estado <= S_BUSCA;
                    end
                end
                default: begin
                    estado <= S_OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: an instruction-level model
// predicts ULA transfers into a scoreboard queue and final pc values.
module tb_unidade_controle;
    import pem_pkg::*;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [7:0] dadosEntrada;
    logic [3:0] enderecoEscrita;
    logic       escrever;
    logic       iniciar;
    logic       acumuladorZero;
    logic [3:0] pc;
    logic       executando;
    logic       parado;

    unidade_controle_if bus ();

    unidade_controle dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .dadosEntrada    (dadosEntrada),
        .enderecoEscrita (enderecoEscrita),
        .escrever        (escrever),
        .iniciar         (iniciar),
        .acumuladorZero  (acumuladorZero),
        .ula             (bus),
        .pc              (pc),
        .executando      (executando),
        .parado          (parado)
    );

    always #5 Clock = ~Clock;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         validSeen   = 0;
    logic [7:0] shadow [16];
    logic [7:0] expectedXfers [$];
    logic [3:0] expPc;
    logic       expHalt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted ULA operation must match the oldest predicted one.
    always @(negedge Clock) begin
        logic [7:0] e;
        if (Resetn && bus.opValido) validSeen++;
        if (Resetn && bus.opValido && bus.ulaPronto) begin
            if (expectedXfers.size() == 0) begin
                checkOutput("unexpected ULA transfer", {24'h0, bus.opcode, bus.operando}, 32'hFFFF);
            end else begin
                e = expectedXfers.pop_front();
                checkOutput("ULA transfer", {bus.opcode, bus.operando}, e);
            end
        end
    end

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic writeMem(input logic [3:0] a, input logic [7:0] d);
        enderecoEscrita = a;
        dadosEntrada    = d;
        escrever        = 1'b1;
        cycle();
        escrever  = 1'b0;
        shadow[a] = d;
    endtask

    task automatic interpret(input logic acz);
        logic [3:0] p;
        logic [7:0] ins;
        p       = 4'h0;
        expHalt = 1'b0;
        for (int s = 0; s < 64 && !expHalt; s++) begin
            ins = shadow[p];
            case (ins[7:4])
                4'h0:    p = p + 4'd1;
                4'hD:    p = acz ? ins[3:0] : p + 4'd1;
                4'hE:    p = ins[3:0];
                4'hF:    expHalt = 1'b1;
                default: begin
                    expectedXfers.push_back(ins);
                    p = p + 4'd1;
                end
            endcase
        end
        expPc = p;
    endtask

    task automatic applyStimulus(input logic acz, input logic doWrite,
                                 input logic [3:0] a, input logic [7:0] d);
        if (doWrite) begin
            enderecoEscrita = a;
            dadosEntrada    = d;
            escrever        = 1'b1;
            shadow[a]       = d;
        end
        interpret(acz);
        acumuladorZero = acz;
        iniciar        = 1'b1;
        cycle();
        iniciar  = 1'b0;
        escrever = 1'b0;
    endtask

    task automatic waitHalt(input string tag);
        for (int n = 0; n < 300; n++) begin
            @(negedge Clock);
            if (parado) break;
        end
        checkOutput({tag, " halted"}, {31'h0, parado}, 32'h1);
        checkOutput({tag, " pc"}, {28'h0, pc}, {28'h0, expPc});
        checkOutput({tag, " scoreboard drained"}, expectedXfers.size(), 0);
        expectedXfers.delete();
        cycle();
    endtask

    initial begin
        logic [7:0] vSeq;
        logic [7:0] eSeq;
        int         cnt;
        int         errs;
        int         execErrs;

        Resetn          = 1'b0;
        escrever        = 1'b0;
        iniciar         = 1'b0;
        acumuladorZero  = 1'b0;
        dadosEntrada    = 8'h00;
        enderecoEscrita = 4'h0;
        bus.ulaPronto   = 1'b1;
        cycle();
        cycle();
        @(negedge Clock);
        checkOutput("reset pc", {28'h0, pc}, 32'h0);
        checkOutput("reset opValido", {31'h0, bus.opValido}, 32'h0);
        checkOutput("reset opcode/operando", {24'h0, bus.opcode, bus.operando}, 32'h0);
        checkOutput("reset executando", {31'h0, executando}, 32'h0);
        checkOutput("reset parado", {31'h0, parado}, 32'h0);
        cycle();
        Resetn = 1'b1;
        for (int a = 0; a < 16; a++) writeMem(4'(a), 8'hF0);

        // One ULA op then HALT, with cycle-exact handshake timing.
        writeMem(4'h0, 8'h13);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        vSeq = '0;
        eSeq = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            vSeq[c-1] = bus.opValido;
            eSeq[c-1] = executando;
            if (c == 3) checkOutput("t1 opcode/operando", {24'h0, bus.opcode, bus.operando}, 32'h13);
            cycle();
        end
        checkOutput("t1 opValido trace", {24'h0, vSeq}, 32'h04);
        checkOutput("t1 executando trace", {24'h0, eSeq}, 32'h1F);
        @(negedge Clock);
        checkOutput("t1 parado", {31'h0, parado}, 32'h1);
        checkOutput("t1 pc", {28'h0, pc}, 32'h1);
        checkOutput("t1 scoreboard drained", expectedXfers.size(), 0);
        cycle();

        // ULA back-pressure: four stalled cycles, accept on the fifth.
        writeMem(4'h0, 8'h25);
        bus.ulaPronto = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        cnt  = 0;
        errs = 0;
        for (int c = 1; c <= 10; c++) begin
            bus.ulaPronto = (c == 7);
            @(negedge Clock);
            if (bus.opValido) begin
                cnt++;
                if ({bus.opcode, bus.operando} != 8'h25) errs++;
            end
            if (pc != ((c <= 7) ? 4'h0 : 4'h1)) errs++;
            cycle();
        end
        bus.ulaPronto = 1'b1;
        checkOutput("t2 opValido cycles", cnt, 5);
        checkOutput("t2 stability/pc errors", errs, 0);
        waitHalt("t2");

        // JMP to a HALT, with the jump written in the same cycle as iniciar.
        validSeen = 0;
        applyStimulus(1'b0, 1'b1, 4'h0, 8'hE5);
        waitHalt("t3 jmp");
        checkOutput("t3 opValido never", validSeen, 0);

        writeMem(4'h0, 8'hD7);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00);
        waitHalt("t4 jz taken");
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        waitHalt("t4 jz not taken");

        // All NOPs: pc walks and wraps while writes are attempted mid-run.
        for (int a = 0; a < 16; a++) writeMem(4'(a), 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        enderecoEscrita = 4'h3;
        dadosEntrada    = 8'hF0;
        escrever        = 1'b1;
        errs     = 0;
        execErrs = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (pc != 4'(((c - 1) / 2) % 16)) errs++;
            if (!executando) execErrs++;
            cycle();
        end
        escrever = 1'b0;
        checkOutput("t5 pc walk errors", errs, 0);
        checkOutput("t5 executando drops", execErrs, 0);
        Resetn = 1'b0;
        cycle();
        Resetn = 1'b1;
        writeMem(4'h5, 8'hF0);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        waitHalt("t5 memory untouched");

        // Reset while the ULA op is offered and accepted in the same cycle.
        writeMem(4'h0, 8'h13);
        acumuladorZero = 1'b0;
        iniciar        = 1'b1;
        cycle();
        iniciar = 1'b0;
        cycle();
        cycle();
        Resetn = 1'b0;
        @(negedge Clock);
        checkOutput("t6 opValido in EXECUTA", {31'h0, bus.opValido}, 32'h1);
        cycle();
        Resetn = 1'b1;
        @(negedge Clock);
        checkOutput("t6 opValido after reset", {31'h0, bus.opValido}, 32'h0);
        checkOutput("t6 pc after reset", {28'h0, pc}, 32'h0);
        checkOutput("t6 idle after reset", {30'h0, executando, parado}, 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        waitHalt("t6 rerun");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
